// File: rtl/sys_array_scheduler_if.sv
// Thread front-end / array side bundle of the systolic array scheduler.
// master = requesters and array feedback, slave = the scheduler.
interface sys_array_scheduler_if #(
    parameter int BITWIDTH  = 16,
    parameter int ADDRWIDTH = 16,
    parameter int MESHUNITS = 4,
    parameter int NTHREADS  = 4
);
    logic [NTHREADS-1:0]                  comp_req, load_req;
    logic [NTHREADS-1:0][ADDRWIDTH-1:0]   A_addr, D_addr, C_addr, comp_stride;
    logic [NTHREADS-1:0][ADDRWIDTH-1:0]   B_addr, load_stride;
    logic [NTHREADS-1:0]                  comp_grant, load_grant, comp_done, load_done;
    logic [MESHUNITS-1:0][ADDRWIDTH-1:0]  A_row_read_addrs, D_col_read_addrs, B_col_read_addrs;
    logic [MESHUNITS-1:0][ADDRWIDTH-1:0]  C_col_write_addrs;
    logic [MESHUNITS-1:0]                 A_read_valid, D_read_valid, B_read_valid;
    logic [MESHUNITS-1:0]                 array_c_valid, C_write_valid;
    logic [MESHUNITS-1:0]                 array_ad_valid, array_b_valid;
    logic [MESHUNITS-1:0][BITWIDTH-1:0]   array_b_shelf_life;
    logic                                 array_propagate;

    modport master (
        output comp_req, load_req, A_addr, D_addr, C_addr, comp_stride, B_addr, load_stride,
               array_c_valid,
        input  comp_grant, load_grant, comp_done, load_done, A_row_read_addrs, D_col_read_addrs,
               B_col_read_addrs, C_col_write_addrs, A_read_valid, D_read_valid, B_read_valid,
               C_write_valid, array_ad_valid, array_b_valid, array_b_shelf_life, array_propagate
    );
    modport slave (
        input  comp_req, load_req, A_addr, D_addr, C_addr, comp_stride, B_addr, load_stride,
               array_c_valid,
        output comp_grant, load_grant, comp_done, load_done, A_row_read_addrs, D_col_read_addrs,
               B_col_read_addrs, C_col_write_addrs, A_read_valid, D_read_valid, B_read_valid,
               C_write_valid, array_ad_valid, array_b_valid, array_b_shelf_life, array_propagate
    );
endinterface

// File: rtl/sys_array_scheduler.sv
// Round-robin compute/load lock arbiter with skewed per-row/column address generation
// for the systolic array; B double-buffer bank flips at the end of every load job.
module sys_array_scheduler #(
    parameter int BITWIDTH  = 16,
    parameter int ADDRWIDTH = 16,
    parameter int MESHUNITS = 4,
    parameter int TILEUNITS = 1,
    parameter int NTHREADS  = 4
) (
    input logic                  clock,
    input logic                  reset,
    sys_array_scheduler_if.slave bus
);
    localparam int MU = MESHUNITS;
    localparam int N  = MESHUNITS * TILEUNITS;
    localparam int PW = $clog2(NTHREADS);
    localparam logic [BITWIDTH-1:0] COMP_LAST = BITWIDTH'(MU * (2 + TILEUNITS) - 1);
    localparam logic [BITWIDTH-1:0] LOAD_LAST = BITWIDTH'(MU * (1 + TILEUNITS));
    localparam logic [BITWIDTH-1:0] NB        = BITWIDTH'(N);

    typedef enum logic {IDLE, BUSY} lock_state_t;
    lock_state_t comp_state, comp_state_n, load_state, load_state_n;

    logic [NTHREADS-1:0]  comp_grant, comp_grant_n, load_grant, load_grant_n;
    logic [NTHREADS-1:0]  comp_elig, load_elig, comp_win, load_win;
    logic [PW-1:0]        comp_ptr, comp_ptr_n, load_ptr, load_ptr_n, comp_sel, load_sel;
    logic [BITWIDTH-1:0]  k, k_n, l, l_n;
    logic [ADDRWIDTH-1:0] a_base, d_base, c_base, c_stride, b_base, b_stride;
    logic                 comp_take, load_take, comp_last, load_last, comp_busy, load_busy, bank;
    logic [MU-1:0]        ad_vld, b_vld;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(NTHREADS - 1)) ? '0 : p + PW'(1);
    endfunction

    // First eligible thread at or after ptr, walking upward with wrap.
    function automatic logic [PW-1:0] rr_pick(input logic [NTHREADS-1:0] elig,
                                              input logic [PW-1:0] ptr);
        logic [PW-1:0] idx, pick;
        logic          found;
        idx   = ptr;
        pick  = ptr;
        found = 1'b0;
        for (int j = 0; j < NTHREADS; j++) begin
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return pick;
    endfunction

    assign comp_busy = (comp_state == BUSY);
    assign load_busy = (load_state == BUSY);
    assign comp_last = comp_busy && (k == COMP_LAST);
    assign load_last = load_busy && (l == LOAD_LAST);

    // Comp arbitrates first; load then excludes both the current comp owner and any new one.
    always_comb begin
        comp_state_n = comp_state;
        comp_grant_n = comp_grant;
        comp_ptr_n   = comp_ptr;
        k_n          = k;
        comp_take    = 1'b0;
        comp_win     = '0;
        comp_elig    = bus.comp_req & ~load_grant;
        comp_sel     = rr_pick(comp_elig, comp_ptr);
        case (comp_state)
            IDLE: if (|comp_elig) begin
                comp_take    = 1'b1;
                comp_win     = NTHREADS'(1) << comp_sel;
                comp_state_n = BUSY;
                comp_grant_n = comp_win;
                comp_ptr_n   = wrap_inc(comp_sel);
                k_n          = '0;
            end
            BUSY: if (comp_last) begin
                comp_state_n = IDLE;
                comp_grant_n = '0;
                k_n          = '0;
            end else begin
                k_n = k + BITWIDTH'(1);
            end
            default: comp_state_n = IDLE;
        endcase

        load_state_n = load_state;
        load_grant_n = load_grant;
        load_ptr_n   = load_ptr;
        l_n          = l;
        load_take    = 1'b0;
        load_win     = '0;
        load_elig    = bus.load_req & ~(comp_grant | comp_win);
        load_sel     = rr_pick(load_elig, load_ptr);
        case (load_state)
            IDLE: if (|load_elig) begin
                load_take    = 1'b1;
                load_win     = NTHREADS'(1) << load_sel;
                load_state_n = BUSY;
                load_grant_n = load_win;
                load_ptr_n   = wrap_inc(load_sel);
                l_n          = '0;
            end
            BUSY: if (load_last) begin
                load_state_n = IDLE;
                load_grant_n = '0;
                l_n          = '0;
            end else begin
                l_n = l + BITWIDTH'(1);
            end
            default: load_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            comp_state <= IDLE;
            load_state <= IDLE;
            comp_grant <= '0;
            load_grant <= '0;
            comp_ptr   <= '0;
            load_ptr   <= '0;
            k          <= '0;
            l          <= '0;
            bank       <= 1'b0;
            a_base     <= '0;
            d_base     <= '0;
            c_base     <= '0;
            c_stride   <= '0;
            b_base     <= '0;
            b_stride   <= '0;
        end else begin
            comp_state <= comp_state_n;
            load_state <= load_state_n;
            comp_grant <= comp_grant_n;
            load_grant <= load_grant_n;
            comp_ptr   <= comp_ptr_n;
            load_ptr   <= load_ptr_n;
            k          <= k_n;
            l          <= l_n;
            if (comp_take) begin
                a_base   <= bus.A_addr[comp_sel];
                d_base   <= bus.D_addr[comp_sel];
                c_base   <= bus.C_addr[comp_sel];
                c_stride <= bus.comp_stride[comp_sel];
            end
            if (load_take) begin
                b_base   <= bus.B_addr[load_sel];
                b_stride <= bus.load_stride[load_sel];
            end
            if (load_last) bank <= ~bank;
        end
    end

    // Windows are tested as (cnt - lo) < N so a counter below lo wraps large and reads inactive.
    for (genvar i = 0; i < MU; i++) begin : g_lane
        localparam logic [BITWIDTH-1:0]  LO  = BITWIDTH'(i);
        localparam logic [BITWIDTH-1:0]  CLO = BITWIDTH'(MU + i);
        localparam logic [ADDRWIDTH-1:0] COL = ADDRWIDTH'(i * TILEUNITS);
        logic                 ad_act, c_act, b_act;
        logic [ADDRWIDTH-1:0] ad_off, c_off, b_off;

        assign ad_act = comp_busy && ((k - LO) < NB);
        assign c_act  = comp_busy && ((k - CLO) < NB);
        assign b_act  = load_busy && ((l - LO) < NB);
        assign ad_off = ADDRWIDTH'(k - LO) * c_stride + COL;
        assign c_off  = ADDRWIDTH'(k - CLO) * c_stride + COL;
        assign b_off  = (ADDRWIDTH'(N - 1) - ADDRWIDTH'(l - LO)) * b_stride + COL;

        assign ad_vld[i]                  = ad_act;
        assign b_vld[i]                   = b_act;
        assign bus.A_row_read_addrs[i]    = ad_act ? a_base + ad_off : '0;
        assign bus.D_col_read_addrs[i]    = ad_act ? d_base + ad_off : '0;
        assign bus.C_col_write_addrs[i]   = c_act ? c_base + c_off : '0;
        assign bus.C_write_valid[i]       = c_act && bus.array_c_valid[i];
        assign bus.B_col_read_addrs[i]    = b_act ? b_base + b_off : '0;
        assign bus.array_b_shelf_life[i]  = b_act ? NB - (l - LO) : '0;
    end

    assign bus.A_read_valid    = ad_vld;
    assign bus.D_read_valid    = ad_vld;
    assign bus.array_ad_valid  = ad_vld;
    assign bus.B_read_valid    = b_vld;
    assign bus.array_b_valid   = b_vld;
    assign bus.comp_grant      = comp_grant;
    assign bus.load_grant      = load_grant;
    assign bus.comp_done       = comp_last ? comp_grant : '0;
    assign bus.load_done       = load_last ? load_grant : '0;
    assign bus.array_propagate = bank;
endmodule

// File: tb/tb_sys_array_scheduler.sv
// Bench for sys_array_scheduler: directed scenarios plus randomized traffic against a
// job-level model (owner, cycle-in-job, latched bases) evaluated with plain arithmetic.
module tb_sys_array_scheduler;
    localparam int NT = 3, MU = 2, TU = 1, N = MU * TU, AW = 16, BW = 16;
    localparam int CL = MU * (2 + TU) - 1;
    localparam int LL = MU * (1 + TU);

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sys_array_scheduler_if #(.BITWIDTH(BW), .ADDRWIDTH(AW), .MESHUNITS(MU), .NTHREADS(NT)) bus ();

    sys_array_scheduler #(.BITWIDTH(BW), .ADDRWIDTH(AW), .MESHUNITS(MU), .TILEUNITS(TU),
                          .NTHREADS(NT)) dut (.clock(clock), .reset(reset), .bus(bus));

    int n_cmp = 0, n_err = 0;

    // model state: owner -1 means lock free
    int m_cown = -1, m_lown = -1, m_k = 0, m_l = 0, m_cptr = 0, m_lptr = 0, m_bank = 0;
    int m_a = 0, m_d = 0, m_c = 0, m_cs = 0, m_b = 0, m_ls = 0;

    logic [NT-1:0]         e_cg, e_lg, e_cd, e_ld;
    logic [MU-1:0][AW-1:0] e_a, e_d, e_b, e_c;
    logic [MU-1:0]         e_av, e_bv, e_cv;
    logic [MU-1:0][BW-1:0] e_sh;
    logic                  e_prop;

    task automatic model_edge();
        int oc, ol, nc, nl;
        oc = m_cown; ol = m_lown; nc = -1; nl = -1;
        if (reset) begin
            m_cown = -1; m_lown = -1; m_k = 0; m_l = 0; m_cptr = 0; m_lptr = 0; m_bank = 0;
            return;
        end
        if (oc >= 0) begin
            if (m_k == CL) m_cown = -1; else m_k++;
        end else begin
            for (int j = 0; j < NT; j++) begin
                int t;
                t = (m_cptr + j) % NT;
                if (nc < 0 && bus.comp_req[t] && t != ol) nc = t;
            end
            if (nc >= 0) begin
                m_cown = nc; m_k = 0; m_cptr = (nc + 1) % NT;
                m_a = bus.A_addr[nc]; m_d = bus.D_addr[nc]; m_c = bus.C_addr[nc];
                m_cs = bus.comp_stride[nc];
            end
        end
        if (ol >= 0) begin
            if (m_l == LL) begin m_lown = -1; m_bank ^= 1; end else m_l++;
        end else begin
            for (int j = 0; j < NT; j++) begin
                int t;
                t = (m_lptr + j) % NT;
                if (nl < 0 && bus.load_req[t] && t != oc && t != nc) nl = t;
            end
            if (nl >= 0) begin
                m_lown = nl; m_l = 0; m_lptr = (nl + 1) % NT;
                m_b = bus.B_addr[nl]; m_ls = bus.load_stride[nl];
            end
        end
    endtask

    task automatic model_outputs();
        e_cg = '0; e_lg = '0; e_cd = '0; e_ld = '0; e_a = '0; e_d = '0; e_b = '0; e_c = '0;
        e_av = '0; e_bv = '0; e_cv = '0; e_sh = '0; e_prop = m_bank[0];
        if (m_cown >= 0) begin
            e_cg = NT'(1) << m_cown;
            if (m_k == CL) e_cd = e_cg;
        end
        if (m_lown >= 0) begin
            e_lg = NT'(1) << m_lown;
            if (m_l == LL) e_ld = e_lg;
        end
        for (int i = 0; i < MU; i++) begin
            int d;
            if (m_cown >= 0) begin
                d = m_k - i;
                if (d >= 0 && d < N) begin
                    e_av[i] = 1'b1;
                    e_a[i] = AW'(m_a + d * m_cs + i * TU);
                    e_d[i] = AW'(m_d + d * m_cs + i * TU);
                end
                d = m_k - MU - i;
                if (d >= 0 && d < N) begin
                    e_c[i]  = AW'(m_c + d * m_cs + i * TU);
                    e_cv[i] = bus.array_c_valid[i];
                end
            end
            if (m_lown >= 0) begin
                d = m_l - i;
                if (d >= 0 && d < N) begin
                    e_bv[i] = 1'b1;
                    e_b[i]  = AW'(m_b + (N - 1 - d) * m_ls + i * TU);
                    e_sh[i] = BW'(N - d);
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.comp_req = '0; bus.load_req = '0; bus.array_c_valid = '0;
        bus.A_addr = '0; bus.D_addr = '0; bus.C_addr = '0; bus.comp_stride = '0;
        bus.B_addr = '0; bus.load_stride = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if ({bus.comp_grant, bus.load_grant, bus.comp_done, bus.load_done} !== '0) begin
            n_err++; $display("FAIL reset_grants_dones got %h exp 0",
                              {bus.comp_grant, bus.load_grant, bus.comp_done, bus.load_done}); end
        n_cmp++; if ({bus.A_row_read_addrs, bus.D_col_read_addrs, bus.B_col_read_addrs,
                      bus.C_col_write_addrs} !== '0) begin
            n_err++; $display("FAIL reset_addrs got %h exp 0", {bus.A_row_read_addrs,
                              bus.D_col_read_addrs, bus.B_col_read_addrs, bus.C_col_write_addrs}); end
        n_cmp++; if ({bus.A_read_valid, bus.B_read_valid, bus.C_write_valid, bus.array_b_shelf_life,
                      bus.array_propagate} !== '0) begin
            n_err++; $display("FAIL reset_valids_shelf_prop got %h exp 0", {bus.A_read_valid,
                              bus.B_read_valid, bus.C_write_valid, bus.array_b_shelf_life,
                              bus.array_propagate}); end
        reset = 1'b0;
    endtask

    task automatic test_single_comp();
        do_reset();
        bus.comp_req = 3'b001; bus.A_addr[0] = 16'h0100; bus.D_addr[0] = 16'h0180;
        bus.C_addr[0] = 16'h0300; bus.comp_stride[0] = 16'd2;
        tick();
        bus.comp_req = '0;
        n_cmp++; if (bus.comp_grant !== 3'b001) begin n_err++;
            $display("FAIL comp_grant_k0 got %b exp 001", bus.comp_grant); end
        n_cmp++; if ({bus.A_read_valid, bus.A_row_read_addrs[0]} !== {2'b01, 16'h0100}) begin n_err++;
            $display("FAIL comp_k0_row0 got %b/%h exp 01/0100", bus.A_read_valid, bus.A_row_read_addrs[0]); end
        tick();
        n_cmp++; if (bus.A_row_read_addrs !== {16'h0101, 16'h0102}) begin n_err++;
            $display("FAIL comp_k1_rows got %h exp 01010102", bus.A_row_read_addrs); end
        n_cmp++; if (bus.D_col_read_addrs !== {16'h0181, 16'h0182}) begin n_err++;
            $display("FAIL comp_k1_dcols got %h exp 01810182", bus.D_col_read_addrs); end
        tick();
        bus.array_c_valid = 2'b11; #1;
        n_cmp++; if ({bus.A_read_valid, bus.A_row_read_addrs[1]} !== {2'b10, 16'h0103}) begin n_err++;
            $display("FAIL comp_k2_row1 got %b/%h exp 10/0103", bus.A_read_valid, bus.A_row_read_addrs[1]); end
        n_cmp++; if ({bus.C_write_valid, bus.C_col_write_addrs[0]} !== {2'b01, 16'h0300}) begin n_err++;
            $display("FAIL comp_k2_c0 got %b/%h exp 01/0300", bus.C_write_valid, bus.C_col_write_addrs[0]); end
        tick();
        bus.array_c_valid = 2'b00; #1;
        n_cmp++; if ({bus.C_write_valid, bus.C_col_write_addrs} !== {2'b00, 16'h0301, 16'h0302}) begin n_err++;
            $display("FAIL comp_k3_c_gated got %b/%h exp 00/03010302", bus.C_write_valid, bus.C_col_write_addrs); end
        tick();
        n_cmp++; if (bus.comp_done !== 3'b000) begin n_err++;
            $display("FAIL comp_done_early got %b exp 000", bus.comp_done); end
        tick();
        n_cmp++; if (bus.comp_done !== 3'b001) begin n_err++;
            $display("FAIL comp_done_k5 got %b exp 001", bus.comp_done); end
        tick();
        n_cmp++; if ({bus.comp_grant, bus.comp_done} !== 6'b0) begin n_err++;
            $display("FAIL comp_release got %b/%b exp 000/000", bus.comp_grant, bus.comp_done); end
    endtask

    task automatic test_single_load();
        do_reset();
        bus.load_req = 3'b010; bus.B_addr[1] = 16'h0200; bus.load_stride[1] = 16'd2;
        tick();
        bus.load_req = '0;
        n_cmp++; if ({bus.load_grant, bus.B_read_valid, bus.B_col_read_addrs[0], bus.array_b_shelf_life[0]}
                     !== {3'b010, 2'b01, 16'h0202, 16'd2}) begin n_err++;
            $display("FAIL load_l0 got %b/%b/%h/%0d exp 010/01/0202/2", bus.load_grant, bus.B_read_valid,
                     bus.B_col_read_addrs[0], bus.array_b_shelf_life[0]); end
        tick();
        n_cmp++; if ({bus.B_col_read_addrs, bus.array_b_shelf_life} !== {16'h0203, 16'h0200, 16'd2, 16'd1}) begin
            n_err++; $display("FAIL load_l1 got %h/%h exp 02030200/00020001", bus.B_col_read_addrs,
                              bus.array_b_shelf_life); end
        tick();
        n_cmp++; if ({bus.array_b_valid, bus.B_col_read_addrs[1], bus.array_b_shelf_life[1]}
                     !== {2'b10, 16'h0201, 16'd1}) begin n_err++;
            $display("FAIL load_l2 got %b/%h/%0d exp 10/0201/1", bus.array_b_valid, bus.B_col_read_addrs[1],
                     bus.array_b_shelf_life[1]); end
        tick(); tick();
        n_cmp++; if ({bus.load_done, bus.array_propagate} !== {3'b010, 1'b0}) begin n_err++;
            $display("FAIL load_done_l4 got %b/%b exp 010/0", bus.load_done, bus.array_propagate); end
        tick();
        n_cmp++; if ({bus.load_grant, bus.array_propagate} !== {3'b000, 1'b1}) begin n_err++;
            $display("FAIL load_bank_toggle got %b/%b exp 000/1", bus.load_grant, bus.array_propagate); end
    endtask

    task automatic test_concurrent();
        do_reset();
        bus.comp_req = 3'b011; bus.load_req = 3'b011;
        tick();
        n_cmp++; if ({bus.comp_grant, bus.load_grant} !== {3'b001, 3'b010}) begin n_err++;
            $display("FAIL concurrent_grants got %b/%b exp 001/010", bus.comp_grant, bus.load_grant); end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++; if ((bus.comp_grant & bus.load_grant) !== 3'b000) begin n_err++;
                $display("FAIL concurrent_disjoint got %b&%b exp 000", bus.comp_grant, bus.load_grant); end
        end
    endtask

    task automatic test_fairness();
        int seq[$], gaps[$], idle, g;
        logic [NT-1:0] prev;
        do_reset();
        bus.comp_req = 3'b111;
        idle = 0; prev = '0;
        for (int c = 0; c < 40 && seq.size() < 4; c++) begin
            tick();
            if (bus.comp_grant == '0) idle++;
            else if (prev == '0) begin
                g = -1;
                for (int t = 0; t < NT; t++) if (bus.comp_grant[t]) g = t;
                seq.push_back(g);
                if (seq.size() > 1) gaps.push_back(idle);
                idle = 0;
            end
            prev = bus.comp_grant;
        end
        n_cmp++; if (seq.size() != 4) begin n_err++;
            $display("FAIL fair_job_count got %0d exp 4 within 40 cycles", seq.size()); end
        for (int j = 0; j < seq.size(); j++) begin
            n_cmp++; if (seq[j] != j % NT) begin n_err++;
                $display("FAIL fair_order[%0d] got %0d exp %0d", j, seq[j], j % NT); end
        end
        for (int j = 0; j < gaps.size(); j++) begin
            n_cmp++; if (gaps[j] != 1) begin n_err++;
                $display("FAIL fair_idle_gap[%0d] got %0d exp 1", j, gaps[j]); end
        end
    endtask

    task automatic test_exclusion();
        do_reset();
        bus.load_req = 3'b100;
        tick();
        bus.load_req = '0; bus.comp_req = 3'b100;
        n_cmp++; if (bus.load_grant !== 3'b100) begin n_err++;
            $display("FAIL excl_load_grant got %b exp 100", bus.load_grant); end
        for (int c = 0; c < LL + 1; c++) begin
            tick();
            n_cmp++; if (bus.comp_grant !== 3'b000) begin n_err++;
                $display("FAIL excl_no_comp[%0d] got %b exp 000", c, bus.comp_grant); end
        end
        tick();
        n_cmp++; if ({bus.comp_grant, bus.load_grant} !== {3'b100, 3'b000}) begin n_err++;
            $display("FAIL excl_comp_after got %b/%b exp 100/000", bus.comp_grant, bus.load_grant); end
    endtask

    task automatic test_reset_mid_job();
        do_reset();
        bus.comp_req = 3'b001; bus.A_addr[0] = 16'h0040; bus.comp_stride[0] = 16'd1;
        tick();
        bus.comp_req = '0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        n_cmp++; if ({bus.comp_grant, bus.comp_done, bus.A_read_valid, bus.C_col_write_addrs} !== '0) begin
            n_err++; $display("FAIL midreset_outputs got %b/%b/%b/%h exp 0", bus.comp_grant, bus.comp_done,
                              bus.A_read_valid, bus.C_col_write_addrs); end
        reset = 1'b0;
        bus.comp_req = 3'b011; bus.load_req = 3'b110;
        tick();
        n_cmp++; if ({bus.comp_grant, bus.load_grant} !== {3'b001, 3'b010}) begin n_err++;
            $display("FAIL midreset_ptrs got %b/%b exp 001/010", bus.comp_grant, bus.load_grant); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.comp_req = NT'($urandom_range(0, 7));
            bus.load_req = NT'($urandom_range(0, 7));
            bus.array_c_valid = MU'($urandom_range(0, 3));
            for (int t = 0; t < NT; t++) begin
                bus.A_addr[t] = AW'($urandom); bus.D_addr[t] = AW'($urandom);
                bus.C_addr[t] = AW'($urandom); bus.B_addr[t] = AW'($urandom);
                bus.comp_stride[t] = AW'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 64));
                bus.load_stride[t] = AW'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 64));
            end
            reset = ($urandom_range(0, 149) == 0);
            #1;
            model_outputs();
            n_cmp++; if ({bus.comp_grant, bus.load_grant} !== {e_cg, e_lg}) begin n_err++;
                $display("FAIL rnd_grants c%0d got %b/%b exp %b/%b", c, bus.comp_grant, bus.load_grant, e_cg, e_lg); end
            n_cmp++; if ({bus.comp_done, bus.load_done} !== {e_cd, e_ld}) begin n_err++;
                $display("FAIL rnd_dones c%0d got %b/%b exp %b/%b", c, bus.comp_done, bus.load_done, e_cd, e_ld); end
            n_cmp++; if ({bus.A_row_read_addrs, bus.D_col_read_addrs, bus.A_read_valid, bus.D_read_valid,
                          bus.array_ad_valid} !== {e_a, e_d, e_av, e_av, e_av}) begin n_err++;
                $display("FAIL rnd_ad c%0d got %h/%h/%b exp %h/%h/%b", c, bus.A_row_read_addrs,
                         bus.D_col_read_addrs, bus.A_read_valid, e_a, e_d, e_av); end
            n_cmp++; if ({bus.C_col_write_addrs, bus.C_write_valid} !== {e_c, e_cv}) begin n_err++;
                $display("FAIL rnd_c c%0d got %h/%b exp %h/%b", c, bus.C_col_write_addrs, bus.C_write_valid, e_c, e_cv); end
            n_cmp++; if ({bus.B_col_read_addrs, bus.array_b_shelf_life, bus.B_read_valid, bus.array_b_valid}
                         !== {e_b, e_sh, e_bv, e_bv}) begin n_err++;
                $display("FAIL rnd_b c%0d got %h/%h/%b exp %h/%h/%b", c, bus.B_col_read_addrs,
                         bus.array_b_shelf_life, bus.B_read_valid, e_b, e_sh, e_bv); end
            n_cmp++; if (bus.array_propagate !== e_prop) begin n_err++;
                $display("FAIL rnd_prop c%0d got %b exp %b", c, bus.array_propagate, e_prop); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_comp();
        test_single_load();
        test_concurrent();
        test_fairness();
        test_exclusion();
        test_reset_mid_job();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sys_array_scheduler.md
# sys_array_scheduler

Multi-thread scheduler for the systolic array: arbitrates a compute lock and a load lock among NTHREADS requesters and generates the skewed per-row/per-column read/write addresses and array control signals for the granted jobs. It is the parametrised successor of the two-thread array controller. It adds per-request row stride, round-robin fairness, per-thread done pulses and explicit double-buffer bank tracking for B. It sits between the thread front-ends and the scratchpad/`sys_array` pair.

## Interface
- BITWIDTH, 16, data/counter width
- ADDRWIDTH, 16, scratchpad address width
- MESHUNITS, 4, mesh rows/cols (MU)
- TILEUNITS, 1, tile units per mesh unit (TU); N = MU*TU
- NTHREADS, 4, requesting threads (≥2)
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- comp_req  in  [NTHREADS]  compute lock request, level
- A_addr, D_addr, C_addr  in  [NTHREADS] x ADDRWIDTH  base addresses, sampled at grant
- comp_stride  in  [NTHREADS] x ADDRWIDTH  row stride for A/D/C, sampled at grant
- load_req  in  [NTHREADS]  load lock request, level
- B_addr, load_stride  in  [NTHREADS] x ADDRWIDTH  B base/stride, sampled at grant
- comp_grant, load_grant  out  [NTHREADS]  one-hot-or-zero lock owner; never same thread
- comp_done, load_done  out  [NTHREADS]  one-cycle pulse to owner on last job cycle
- A_row_read_addrs, D_col_read_addrs, B_col_read_addrs  out  [MU] x ADDRWIDTH
- A_read_valid, D_read_valid, B_read_valid  out  [MU]
- array_c_valid  in  [MU]  AND-reduced column C valid from array
- C_col_write_addrs  out  [MU] x ADDRWIDTH;  C_write_valid  out  [MU]
- array_ad_valid, array_b_valid  out  [MU]  array input valids (broadcast over TU)
- array_b_shelf_life  out  [MU] x BITWIDTH
- array_propagate  out  1  active B bank select

## Operation
- States per lock: IDLE, BUSY. Counters k (comp) and l (load) clear at grant and increment each BUSY cycle.
- Arbitration, evaluated each edge:
  - Comp first: eligible = comp_req & ~load_grant; round-robin from comp_ptr.
  - Load second: eligible = load_req & ~(comp owner, including one granted this edge); round-robin from load_ptr.
  - The pointer moves to winner+1 mod NTHREADS.
  - Both locks may be granted at the same edge.
- Comp, row/col i active while i ≤ k < i+N:
  - A/D addr = base + (k−i)*stride + i*TU.
  - A_read_valid[i] = D_read_valid[i] = array_ad_valid[i] = 1.
- C column i window: MU+i ≤ k < MU+i+N.
  - addr = C_base + (k−MU−i)*stride + i*TU.
  - C_write_valid[i] = array_c_valid[i].
- COMP_LAST = MU*(2+TU)−1. comp_done[owner] pulses when k == COMP_LAST.
- Load, col i active while i ≤ l < i+N:
  - addr = B_base + (N−1−(l−i))*stride + i*TU.
  - shelf_life = N−(l−i).
  - B_read_valid[i] = array_b_valid[i] = 1.
- LOAD_LAST = MU*(1+TU). load_done[owner] pulses when l == LOAD_LAST.
- array_propagate = bank register. The bank toggles at the edge ending each load job.
- Address arithmetic is modulo 2^ADDRWIDTH; wrap is silent.

## Timing
- Reset values:
  - All grants, dones, valids, addresses, shelf_life = 0.
  - propagate = 0.
  - Pointers = 0; counters = 0.
- Grant latency: request seen at edge e → grant high after e. k = 0 in the first BUSY cycle, so the first reads are issued in the cycle the grant is visible.
- Release: the lock clears at the edge ending the done cycle. That edge cannot re-grant the same lock; at least one IDLE cycle follows.
- All address/valid outputs are combinational from counters/bases. They are 0 whenever the lock is IDLE or the row/col is outside its window.
- Requests dropped mid-job are ignored: a job always runs to LAST.
- Reset mid-job aborts both locks immediately, with no done pulse.

## Test plan
- Single comp (MU=2, TU=1, NTHREADS=3): thread 0, A=0x100, stride 2, C=0x300 →
  - k0: row0 = 0x100 valid, row1 invalid.
  - k1: row0 = 0x102, row1 = 0x101.
  - k2: row1 = 0x103.
  - C col0 writes 0x300/0x302 at k2/k3, gated by array_c_valid.
  - comp_done[0] at k5; grant drops next cycle.
- Single load: thread 1, B=0x200, stride 2 →
  - l0: col0 = 0x202, shelf 2.
  - l1: col0 = 0x200 shelf 1; col1 = 0x203 shelf 2.
  - l2: col1 = 0x201 shelf 1.
  - load_done[1] at l4; propagate toggles 0→1.
- Concurrent: comp_req = load_req = 3'b011 from reset → comp_grant = 001, load_grant = 010 on the same edge. The grants never share a bit.
- Fairness: comp_req = 3'b111 held → successive grants go 0, 1, 2, 0 with one IDLE cycle between jobs.
- Exclusion: thread 2 holds the load lock, comp_req = 3'b100 only → no comp grant until the load releases.
- Reset at k3 → all outputs 0 next cycle, no comp_done, pointers 0.
